// File: rtl/main_memory_responder_if.sv
// Memory-port bundle between the cache controller (master) and the main-memory model (slave).
// Clock and reset stay outside the bundle.
interface main_memory_responder_if;
   logic        mem_valid;
   logic        mem_rd_wr;
   logic [31:0] mem_add;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic        mem_busy;
   logic        addr_error;
   logic [31:0] total_reads;
   logic [31:0] total_writes;

   modport master (
      output mem_valid,
      output mem_rd_wr,
      output mem_add,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready,
      input  mem_busy,
      input  addr_error,
      input  total_reads,
      input  total_writes
   );

   modport slave (
      input  mem_valid,
      input  mem_rd_wr,
      input  mem_add,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready,
      output mem_busy,
      output addr_error,
      output total_reads,
      output total_writes
   );
endinterface

// File: rtl/main_memory_responder.sv
// Byte-wide main-memory model: pattern fill after reset, then one request per cycle answered
// after a fixed READ_LATENCY, strictly in order, with read/write counters.
module main_memory_responder #(
   parameter int unsigned MEM_DEPTH_BITS = 16,
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          INIT_ENABLE    = 1'b1
) (
   input logic                    clk,
   input logic                    reset,
   main_memory_responder_if.slave mem
);

   localparam int unsigned MemBytes = 2 ** MEM_DEPTH_BITS;

   typedef enum logic [0:0] {StFill, StServe} state_e;

   state_e                    state_q, state_d;
   logic [MEM_DEPTH_BITS-1:0] fill_cnt_q, fill_cnt_d;
   logic [31:0]               total_reads_q, total_reads_d;
   logic [31:0]               total_writes_q, total_writes_d;

   // Storage has no reset: contents survive reset when the fill is disabled.
   logic [7:0]                mem_q [MemBytes];

   logic                      acc;
   logic                      in_range;
   logic [MEM_DEPTH_BITS-1:0] req_addr;
   logic [7:0]                rsp_data;
   logic                      rsp_err;
   logic                      we;
   logic [MEM_DEPTH_BITS-1:0] waddr;
   logic [7:0]                wdata;

   // Request decode; the array read sees every write from earlier edges.
   always_comb begin
      acc      = (state_q == StServe) && mem.mem_valid;
      in_range = (mem.mem_add >> MEM_DEPTH_BITS) == 32'd0;
      req_addr = mem.mem_add[MEM_DEPTH_BITS-1:0];
      rsp_data = (acc && mem.mem_rd_wr && in_range) ? mem_q[req_addr] : 8'h00;
      rsp_err  = acc && !in_range;
   end

   always_comb begin
      state_d        = state_q;
      fill_cnt_d     = fill_cnt_q;
      total_reads_d  = total_reads_q;
      total_writes_d = total_writes_q;
      we             = 1'b0;
      waddr          = req_addr;
      wdata          = mem.mem_wdata;
      unique case (state_q)
         StFill: begin
            we         = 1'b1;
            waddr      = fill_cnt_q;
            wdata      = 8'(fill_cnt_q) ^ 8'hA5;
            fill_cnt_d = fill_cnt_q + MEM_DEPTH_BITS'(1);
            if (&fill_cnt_q) begin
               state_d = StServe;
            end
         end
         StServe: begin
            if (mem.mem_valid) begin
               if (mem.mem_rd_wr) begin
                  total_reads_d = total_reads_q + 32'd1;
               end else begin
                  total_writes_d = total_writes_q + 32'd1;
                  we             = in_range;
               end
            end
         end
         default: state_d = StServe;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= INIT_ENABLE ? StFill : StServe;
         fill_cnt_q     <= '0;
         total_reads_q  <= 32'd0;
         total_writes_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         fill_cnt_q     <= fill_cnt_d;
         total_reads_q  <= total_reads_d;
         total_writes_q <= total_writes_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign mem.mem_busy     = (state_q == StFill);
   assign mem.total_reads  = total_reads_q;
   assign mem.total_writes = total_writes_q;

   if (READ_LATENCY == 0) begin : g_comb
      assign mem.mem_ready  = acc;
      assign mem.mem_rdata  = rsp_data;
      assign mem.addr_error = rsp_err;
   end else begin : g_pipe
      logic [READ_LATENCY-1:0] vld_q, vld_d;
      logic [READ_LATENCY-1:0] err_q, err_d;
      logic [7:0]              data_q [READ_LATENCY];
      logic [7:0]              data_d [READ_LATENCY];

      // Stage 0 captures at the acceptance edge; data is already zero for non-reads.
      always_comb begin
         vld_d     = '0;
         err_d     = '0;
         data_d    = '{default: 8'h00};
         vld_d[0]  = acc;
         err_d[0]  = rsp_err;
         data_d[0] = rsp_data;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '{default: 8'h00};
         end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            data_q <= data_d;
         end
      end

      assign mem.mem_ready  = vld_q[READ_LATENCY-1];
      assign mem.mem_rdata  = data_q[READ_LATENCY-1];
      assign mem.addr_error = err_q[READ_LATENCY-1];
   end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: a 256-byte, latency-2 instance with fill, and a 256-byte, latency-0
// instance without fill.
module tb_main_memory_responder;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_tests;
   int   n_fail;

   main_memory_responder_if mif_a ();
   main_memory_responder_if mif_b ();

   main_memory_responder #(
      .MEM_DEPTH_BITS(8),
      .READ_LATENCY  (2),
      .INIT_ENABLE   (1'b1)
   ) u_dut_a (
      .clk  (clk),
      .reset(rst_a),
      .mem  (mif_a.slave)
   );

   main_memory_responder #(
      .MEM_DEPTH_BITS(8),
      .READ_LATENCY  (0),
      .INIT_ENABLE   (1'b0)
   ) u_dut_b (
      .clk  (clk),
      .reset(rst_b),
      .mem  (mif_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_a(input logic vld, input logic rd, input logic [31:0] addr,
                          input logic [7:0] wd);
      mif_a.mem_valid = vld;
      mif_a.mem_rd_wr = rd;
      mif_a.mem_add   = addr;
      mif_a.mem_wdata = wd;
   endtask

   // Starts right after reset release; a read is held on the port throughout the fill.
   task automatic run_fill(input string tag);
      int busy_cnt;
      int rdy_cnt;
      busy_cnt = 0;
      rdy_cnt  = 0;
      drive_a(1'b1, 1'b1, 32'h12, 8'h00);
      for (int k = 0; k < 255; k++) begin
         tick();
         busy_cnt += int'(mif_a.mem_busy);
         rdy_cnt  += int'(mif_a.mem_ready);
      end
      chk({tag, "_busy_255_edges"}, busy_cnt, 255);
      tick();
      rdy_cnt += int'(mif_a.mem_ready);
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      chk({tag, "_busy_drop"}, 32'(mif_a.mem_busy), 0);
      chk({tag, "_no_ready_in_fill"}, rdy_cnt, 0);
      chk({tag, "_no_reads_in_fill"}, mif_a.total_reads, 0);
   endtask

   logic [7:0]  exp_d;
   logic        s_rd  [5];
   logic [31:0] s_ad  [5];
   logic [7:0]  s_wd  [5];
   logic        s_err [5];
   logic [7:0]  s_dat [5];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      mif_b.mem_valid = 1'b0;
      mif_b.mem_rd_wr = 1'b0;
      mif_b.mem_add   = 32'h0;
      mif_b.mem_wdata = 8'h00;
      tick();

      // Reset state
      chk("rst_ready", 32'(mif_a.mem_ready), 0);
      chk("rst_rdata", 32'(mif_a.mem_rdata), 0);
      chk("rst_err", 32'(mif_a.addr_error), 0);
      chk("rst_busy_a", 32'(mif_a.mem_busy), 1);
      chk("rst_reads", mif_a.total_reads, 0);
      chk("rst_writes", mif_a.total_writes, 0);
      chk("rst_busy_b", 32'(mif_b.mem_busy), 0);

      // 1: fill of 256 edges, then read 0x12 -> 0x12^0xA5 = 0xB7 two cycles later
      rst_a = 1'b0;
      run_fill("t1");
      drive_a(1'b1, 1'b1, 32'h12, 8'h00);
      tick();
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      chk("t1_ready_n1", 32'(mif_a.mem_ready), 0);
      tick();
      chk("t1_ready_n2", 32'(mif_a.mem_ready), 1);
      chk("t1_rdata", 32'(mif_a.mem_rdata), 32'hB7);
      chk("t1_err", 32'(mif_a.addr_error), 0);
      tick();
      chk("t1_ready_after", 32'(mif_a.mem_ready), 0);
      chk("t1_rdata_after", 32'(mif_a.mem_rdata), 0);

      // 2: 16 back-to-back reads 0x40..0x4F; response for request i-1 is visible after tick i
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) drive_a(1'b1, 1'b1, 32'h40 + 32'(i), 8'h00);
         else drive_a(1'b0, 1'b0, 32'h0, 8'h00);
         tick();
         if (i >= 1) begin
            exp_d = (8'h40 + 8'(i - 1)) ^ 8'hA5;
            chk($sformatf("t2_ready_%0d", i - 1), 32'(mif_a.mem_ready), 1);
            chk($sformatf("t2_rdata_%0d", i - 1), 32'(mif_a.mem_rdata), 32'(exp_d));
         end
      end
      tick();
      chk("t2_ready_end", 32'(mif_a.mem_ready), 0);
      chk("t2_reads", mif_a.total_reads, 17);  // 1 from test 1 plus 16

      // 3: write 0x3C=0x5A then read 0x3C next cycle
      drive_a(1'b1, 1'b0, 32'h3C, 8'h5A);
      tick();
      drive_a(1'b1, 1'b1, 32'h3C, 8'h00);
      tick();
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      chk("t3_wr_ready", 32'(mif_a.mem_ready), 1);
      chk("t3_wr_rdata", 32'(mif_a.mem_rdata), 0);
      tick();
      chk("t3_rd_ready", 32'(mif_a.mem_ready), 1);
      chk("t3_rd_rdata", 32'(mif_a.mem_rdata), 32'h5A);
      tick();
      chk("t3_ready_end", 32'(mif_a.mem_ready), 0);
      chk("t3_writes", mif_a.total_writes, 1);
      chk("t3_reads", mif_a.total_reads, 18);

      // 4: out-of-range write/read, no aliasing onto 0x000, high address bit
      s_rd[0] = 1'b0; s_ad[0] = 32'h100;      s_wd[0] = 8'hFF; s_err[0] = 1'b1; s_dat[0] = 8'h00;
      s_rd[1] = 1'b1; s_ad[1] = 32'h100;      s_wd[1] = 8'h00; s_err[1] = 1'b1; s_dat[1] = 8'h00;
      s_rd[2] = 1'b1; s_ad[2] = 32'h000;      s_wd[2] = 8'h00; s_err[2] = 1'b0; s_dat[2] = 8'hA5;
      s_rd[3] = 1'b1; s_ad[3] = 32'h80000012; s_wd[3] = 8'h00; s_err[3] = 1'b1; s_dat[3] = 8'h00;
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) drive_a(1'b1, s_rd[i], s_ad[i], s_wd[i]);
         else drive_a(1'b0, 1'b0, 32'h0, 8'h00);
         tick();
         if (i >= 1) begin
            chk($sformatf("t4_ready_%0d", i - 1), 32'(mif_a.mem_ready), 1);
            chk($sformatf("t4_err_%0d", i - 1), 32'(mif_a.addr_error), 32'(s_err[i-1]));
            chk($sformatf("t4_rdata_%0d", i - 1), 32'(mif_a.mem_rdata), 32'(s_dat[i-1]));
         end
      end
      tick();
      chk("t4_err_end", 32'(mif_a.addr_error), 0);
      chk("t4_writes", mif_a.total_writes, 2);
      chk("t4_reads", mif_a.total_reads, 21);

      // 5: reset with two reads in flight, then refill restores 0x3C to 0x3C^0xA5 = 0x99
      drive_a(1'b1, 1'b1, 32'h10, 8'h00);
      tick();
      drive_a(1'b1, 1'b1, 32'h11, 8'h00);
      tick();
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      chk("t5_inflight_ready", 32'(mif_a.mem_ready), 1);
      rst_a = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(mif_a.mem_ready), 0);
      chk("t5_rst_rdata", 32'(mif_a.mem_rdata), 0);
      chk("t5_rst_reads", mif_a.total_reads, 0);
      chk("t5_rst_writes", mif_a.total_writes, 0);
      chk("t5_rst_busy", 32'(mif_a.mem_busy), 1);
      tick();
      rst_a = 1'b0;
      run_fill("t5");
      drive_a(1'b1, 1'b1, 32'h3C, 8'h00);
      tick();
      drive_a(1'b0, 1'b0, 32'h0, 8'h00);
      tick();
      chk("t5_rd_ready", 32'(mif_a.mem_ready), 1);
      chk("t5_rd_rdata", 32'(mif_a.mem_rdata), 32'h99);

      // 6: latency 0, no fill: combinational responses in the request cycle
      rst_b = 1'b0;
      #1;
      chk("t6_busy", 32'(mif_b.mem_busy), 0);
      chk("t6_idle_ready", 32'(mif_b.mem_ready), 0);
      mif_b.mem_valid = 1'b1;
      mif_b.mem_rd_wr = 1'b0;
      mif_b.mem_add   = 32'h20;
      mif_b.mem_wdata = 8'h3E;
      #1;
      chk("t6_wr_ready", 32'(mif_b.mem_ready), 1);
      chk("t6_wr_rdata", 32'(mif_b.mem_rdata), 0);
      tick();
      mif_b.mem_rd_wr = 1'b1;
      mif_b.mem_wdata = 8'h00;
      #1;
      chk("t6_rd_ready", 32'(mif_b.mem_ready), 1);
      chk("t6_rd_rdata", 32'(mif_b.mem_rdata), 32'h3E);
      chk("t6_writes", mif_b.total_writes, 1);
      tick();
      mif_b.mem_add = 32'h1FF;
      #1;
      chk("t6_oor_err", 32'(mif_b.addr_error), 1);
      chk("t6_oor_rdata", 32'(mif_b.mem_rdata), 0);
      chk("t6_reads", mif_b.total_reads, 1);
      tick();
      mif_b.mem_valid = 1'b0;
      #1;
      chk("t6_idle_after", 32'(mif_b.mem_ready), 0);
      chk("t6_err_after", 32'(mif_b.addr_error), 0);
      chk("t6_reads_end", mif_b.total_reads, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
